alu_share_arb: RTL



---
 rtl/alu_share_arb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter that time-shares one accum5 ALU datapath.
// A transaction is latched in IDLE, issued for one cycle, waited out for the
// ALU latency, captured, and returned to the winner with a one-cycle done.
module alu_share_arb #(
    parameter int W         = 4,
    parameter int LAT       = 1,
    parameter int NUM_MODES = 12
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [3:0]   m0,
    input  logic         cin0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic [3:0]   m1,
    input  logic         cin1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] rsp_r,
    output logic         rsp_of,
    output logic         rsp_err,
    output logic         alu_en,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_m,
    output logic         alu_cin,
    input  logic [W-1:0] alu_r,
    input  logic         alu_of
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    localparam int CW = 4;
    // WAIT spans LAT-1 cycles: the counter is loaded with LAT-2 and WAIT exits on zero
    localparam logic [CW-1:0] WAIT_LOAD = CW'((LAT > 1) ? (LAT - 2) : 0);

    state_t         state;
    state_t         state_nxt;
    logic           rr;
    logic           sel;
    logic [CW-1:0]  cnt;

    logic           any_req;
    logic           pick1;
    logic [W-1:0]   pick_a;
    logic [W-1:0]   pick_b;
    logic [3:0]     pick_m;
    logic           pick_cin;
    logic           pick_legal;

    // Winner selection: a lone requester wins, contention goes to the rr pointer
    always_comb begin
        any_req    = req0 | req1;
        pick1      = req1 & (~req0 | rr);
        pick_a     = pick1 ? a1   : a0;
        pick_b     = pick1 ? b1   : b0;
        pick_m     = pick1 ? m1   : m0;
        pick_cin   = pick1 ? cin1 : cin0;
        pick_legal = ({28'd0, pick_m} < 32'(NUM_MODES));
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = pick_legal ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: state_nxt = (LAT > 1) ? S_WAIT : S_CAPT;
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_CAPT;
                end
            end
            S_CAPT:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, wait counter, response capture and rr pointer
    // The alu_* output registers double as the operand latches; an illegal
    // request never loads them, so they keep their last issued values.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            rr      <= 1'b0;
            sel     <= 1'b0;
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_m   <= '0;
            alu_cin <= 1'b0;
            rsp_r   <= '0;
            rsp_of  <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        sel <= pick1;
                        if (pick_legal) begin
                            alu_a   <= pick_a;
                            alu_b   <= pick_b;
                            alu_m   <= pick_m;
                            alu_cin <= pick_cin;
                        end else begin
                            rsp_r   <= '0;
                            rsp_of  <= 1'b0;
                            rsp_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CAPT: begin
                    rsp_r   <= alu_r;
                    rsp_of  <= alu_of;
                    rsp_err <= 1'b0;
                end
                S_DONE: begin
                    rr      <= ~sel;
                    rsp_r   <= '0;
                    rsp_of  <= 1'b0;
                    rsp_err <= 1'b0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Grant, done and issue strobes decoded from state and the selected requester
    always_comb begin
        gnt0   = (state != S_IDLE) & ~sel;
        gnt1   = (state != S_IDLE) &  sel;
        done0  = (state == S_DONE) & ~sel;
        done1  = (state == S_DONE) &  sel;
        alu_en = (state == S_ISSUE);
    end

endmodule
